// File: rtl/count_scan_ctrl_pkg.sv
// Shared types and constants for the BCD count/scan controller: FSM states,
// seven-segment patterns and the BCD arithmetic helpers.
package count_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Ripple one step up or down through the packed BCD digits; out-of-range
    // digits fold back into 0..9 so a corrupted value can never persist.
    function automatic logic [4*NUM_DIGITS-1:0] bcd_advance(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic                    up
    );
        logic [4*NUM_DIGITS-1:0] res;
        logic                    carry;
        logic [3:0]              d;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = val[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        res[4*i +: 4] = 4'd0;
                        carry         = 1'b1;
                    end else begin
                        res[4*i +: 4] = d + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        res[4*i +: 4] = 4'd9;
                        carry         = 1'b1;
                    end else if (d > 4'd9) begin
                        res[4*i +: 4] = 4'd9;
                        carry         = 1'b0;
                    end else begin
                        res[4*i +: 4] = d - 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    function automatic logic bcd_at_limit(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic                    up
    );
        return up ? (val == 16'h9999) : (val == 16'h0000);
    endfunction

endpackage

// File: rtl/count_scan_ctrl_seg7_decode.sv
// Combinational BCD digit to seven-segment pattern; non-BCD codes blank.
module seg7_decode
    import count_scan_ctrl_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_scan_ctrl.sv
// Four-digit BCD up/down counter with start/stop/clear control and a
// multiplexed seven-segment scan driver sharing one decoder.
//
// state   | meaning
// IDLE    | count zeroed, waiting for start
// RUN     | tick counter running, bcd advances every TICK_DIV cycles
// HOLD    | paused; tick count and bcd frozen until start
module count_scan_ctrl
    import count_scan_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        up_dn,
    output logic [15:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        running,
    output logic        wrap
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [15:0] bcd_q, bcd_d;
    logic        wrap_q, wrap_d;
    logic        running_q, running_d;

    logic [15:0] scan_q, scan_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        scan_tc;
    logic [3:0]  dec_digit;
    logic [6:0]  dec_seg;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bcd_d   = bcd_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stop && start) state_d = ST_RUN;
            end
            ST_RUN: begin
                // A stop on the terminal tick wins: no advance, count held.
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = 16'd0;
                    bcd_d  = bcd_advance(bcd_q, up_dn);
                    wrap_d = bcd_at_limit(bcd_q, up_dn);
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (!stop && start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            tick_d  = 16'd0;
            bcd_d   = 16'd0;
            wrap_d  = 1'b0;
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= 16'd0;
            bcd_q     <= 16'd0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bcd_q     <= bcd_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    // The decoder looks at the digit about to be selected so seg and an
    // change together on the scan edge.
    always_comb begin
        scan_tc   = (scan_q == SCAN_LAST);
        scan_d    = scan_tc ? 16'd0 : scan_q + 16'd1;
        idx_d     = scan_tc ? idx_q + 2'd1 : idx_q;
        an_d      = scan_tc ? {an_q[2:0], an_q[3]} : an_q;
        dec_digit = bcd_q[{idx_d, 2'b00} +: 4];
        seg_d     = scan_tc ? dec_seg : seg_q;
    end

    seg7_decode u_seg7_decode (
        .digit_i (dec_digit),
        .seg_o   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= 16'd0;
            idx_q  <= 2'd0;
            an_q   <= 4'b0001;
            seg_q  <= SEG_0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bcd     = bcd_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_count_scan_ctrl.sv
// Scoreboard bench for count_scan_ctrl: an integer-level reference model
// queues the expected outputs each cycle and a monitor compares them.
module tb_count_scan_ctrl;

    localparam int TICK_DIV = 10;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] SEGTAB [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    logic        clk = 1'b0;
    logic        reset, start, stop, clear, up_dn;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        running, wrap;

    always #5 clk = ~clk;

    count_scan_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .up_dn   (up_dn),
        .bcd     (bcd),
        .an      (an),
        .seg     (seg),
        .running (running),
        .wrap    (wrap)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        running;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic int digit_of(input int value, input int pos);
        int p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        return (value / p) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(digit_of(value, i));
        return r;
    endfunction

    // Reference model: mode 0 idle, 1 run, 2 hold; count kept as 0..9999.
    int         m_mode  = 0;
    int         m_count = 0;
    int         m_tick  = 0;
    int         m_scan  = 0;
    int         m_pos   = 0;
    logic [6:0] m_seg   = 7'b0111111;
    logic       m_wrap  = 1'b0;

    initial begin : model
        int   prev;
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = 0; m_count = 0; m_tick = 0;
                m_scan = 0; m_pos = 0; m_seg = SEGTAB[0]; m_wrap = 1'b0;
            end else begin
                prev = m_count;
                if (m_scan == SCAN_DIV - 1) begin
                    m_scan = 0;
                    m_pos  = (m_pos + 1) % 4;
                    m_seg  = SEGTAB[digit_of(prev, m_pos)];
                end else begin
                    m_scan = m_scan + 1;
                end
                m_wrap = 1'b0;
                if (clear) begin
                    m_mode = 0; m_count = 0; m_tick = 0;
                end else if (m_mode == 1) begin
                    if (stop) begin
                        m_mode = 2;
                    end else if (m_tick == TICK_DIV - 1) begin
                        m_tick = 0;
                        if (up_dn) begin
                            m_wrap  = (m_count == 9999);
                            m_count = (m_count + 1) % 10000;
                        end else begin
                            m_wrap  = (m_count == 0);
                            m_count = (m_count + 9999) % 10000;
                        end
                    end else begin
                        m_tick = m_tick + 1;
                    end
                end else if (!stop && start) begin
                    m_mode = 1;
                end
            end
            e.bcd     = to_bcd(m_count);
            e.an      = 4'(1 << m_pos);
            e.seg     = m_seg;
            e.running = (m_mode == 1);
            e.wrap    = m_wrap;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({bcd, an, seg, running, wrap} !== e) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t got bcd=%h an=%b seg=%b run=%b wrap=%b expected bcd=%h an=%b seg=%b run=%b wrap=%b",
                             $time, bcd, an, seg, running, wrap,
                             e.bcd, e.an, e.seg, e.running, e.wrap);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin : stimulus
        int guard;
        logic [3:0] an_exp [4];
        an_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; up_dn = 1'b1;
        step(3);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_an", 32'(an), 32'h1);
        check("reset_seg", 32'(seg), 32'(SEGTAB[0]));
        check("reset_running", 32'(running), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        reset = 1'b0;
        step(2);
        check("idle_running", 32'(running), 32'h0);

        // start pulse, first and second advance
        start = 1'b1; step(1); start = 1'b0;
        check("start_running", 32'(running), 32'h1);
        step(9);  check("pre_first_tick", 32'(bcd), 32'h0000);
        step(1);  check("first_tick", 32'(bcd), 32'h0001);
        step(10); check("second_tick", 32'(bcd), 32'h0002);

        // pause after 5 ticks, resume continues from the held tick count
        step(5);
        stop = 1'b1; step(1); stop = 1'b0;
        check("hold_running", 32'(running), 32'h0);
        step(50); check("hold_frozen", 32'(bcd), 32'h0002);
        start = 1'b1; step(1); start = 1'b0;
        check("resume_running", 32'(running), 32'h1);
        step(4); check("resume_pre", 32'(bcd), 32'h0002);
        step(1); check("resume_adv", 32'(bcd), 32'h0003);

        // clear beats stop and start together
        clear = 1'b1; stop = 1'b1; start = 1'b1; step(1);
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        check("clear_running", 32'(running), 32'h0);
        check("clear_bcd", 32'(bcd), 32'h0000);
        step(3); check("clear_stays_idle", 32'(running), 32'h0);

        // down wrap, up wrap, down wrap again
        up_dn = 1'b0; start = 1'b1; step(1); start = 1'b0;
        step(9);  check("down_pre", 32'(bcd), 32'h0000);
        step(1);  check("down_wrap_bcd", 32'(bcd), 32'h9999);
        check("down_wrap_pulse", 32'(wrap), 32'h1);
        step(1);  check("down_wrap_end", 32'(wrap), 32'h0);
        up_dn = 1'b1;
        step(8);  check("up_pre", 32'(bcd), 32'h9999);
        step(1);  check("up_wrap_bcd", 32'(bcd), 32'h0000);
        check("up_wrap_pulse", 32'(wrap), 32'h1);
        step(1);  check("up_wrap_end", 32'(wrap), 32'h0);
        up_dn = 1'b0;
        step(9);  check("down2_wrap_bcd", 32'(bcd), 32'h9999);
        check("down2_wrap_pulse", 32'(wrap), 32'h1);
        step(10); check("down_9998", 32'(bcd), 32'h9998);

        // count to 1234, hold, then watch the scan
        clear = 1'b1; step(1); clear = 1'b0;
        up_dn = 1'b1; start = 1'b1; step(1); start = 1'b0;
        step(12340);
        stop = 1'b1; step(1); stop = 1'b0;
        check("reach_1234", 32'(bcd), 32'h1234);
        guard = 0;
        while (an !== 4'b1000 && guard < 20) begin step(1); guard++; end
        while (an === 4'b1000 && guard < 40) begin step(1); guard++; end
        check("scan_an_0", 32'(an), 32'(an_exp[0]));
        check("scan_seg_0", 32'(seg), 32'(SEGTAB[4]));
        for (int k = 1; k < 4; k++) begin
            step(SCAN_DIV);
            check("scan_an", 32'(an), 32'(an_exp[k]));
            check("scan_seg", 32'(seg), 32'(SEGTAB[4 - k]));
        end

        // randomized commands, checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            clear = ($urandom_range(0, 63) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 7) == 0);
            up_dn = 1'($urandom_range(0, 1));
            step(1);
        end
        reset = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0;
        step(2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
